// File: rtl/restador_serial_pkg.sv
// restador_serial_pkg: shared state encoding and default width for the serial subtractor
package restador_serial_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/restador_serial_if.sv
// restador_serial_if: start/busy/done handshake and operand/result bus of the serial subtractor
interface restador_serial_if import restador_serial_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bi;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bo;
  modport master (output start, a, b, bi, input busy, done, d, bo);
  modport slave  (input start, a, b, bi, output busy, done, d, bo);
endinterface

// File: rtl/restador_serial_completo.sv
// restador_completo: combinational 1-bit full subtractor cell, PwrC only tags the instance for power runs
module restador_completo #(
  parameter int PwrC = 0
) (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

// File: rtl/restador_serial.sv
// restador_serial: bit-serial A-B-Bin subtractor, LSB first; RESTADOR_SAT_EN clamps underflow results to 0
module restador_serial import restador_serial_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PwrC  = 0
) (
  input  logic              clk,
  input  logic              reset_L,
  restador_serial_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh, full, res;
  logic [WIDTH-2:0] r_sh;
  logic [CW-1:0]    cnt;
  logic             br, diff, bo_c;
  restador_completo #(.PwrC(PwrC)) u_cell (
    .a (a_sh[0]),
    .b (b_sh[0]),
    .bi(br),
    .d (diff),
    .bo(bo_c)
  );
  assign full = {diff, r_sh};
`ifdef RESTADOR_SAT_EN
  assign res = bo_c ? '0 : full;
`else
  assign res = full;
`endif
  // Handshake FSM plus the operand/result shift datapath, one bit per cycle
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state    <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.d    <= '0;
      bus.bo   <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      r_sh     <= '0;
      br       <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          bus.busy <= bus.start;
          state    <= bus.start ? SHIFT : IDLE;
          if (bus.start) begin
            a_sh <= bus.a;
            b_sh <= bus.b;
            br   <= bus.bi;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          r_sh <= full[WIDTH-1:1];
          br   <= bo_c;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            bus.d    <= res;
            bus.bo   <= bo_c;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_restador_serial.sv
// tb_restador_serial: directed and random checks of restador_serial against an arithmetic model
module tb_restador_serial;
  localparam int W = 8;
  logic clk = 1'b0;
  logic reset_L = 1'b0;
  int   total = 0;
  int   passed = 0;
  int   done_cnt = 0;
  int   base;
  restador_serial_if #(.WIDTH(W)) bus ();
  restador_serial #(.WIDTH(W), .PwrC(0)) dut (
    .clk    (clk),
    .reset_L(reset_L),
    .bus    (bus)
  );
  always #5 clk = ~clk;
  // Count done pulses away from the active edge
  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    int t;
    logic [W-1:0] dd;
    logic bb;
    t  = int'(a) - int'(b) - int'(bi);
    bb = (t < 0);
    dd = t[W-1:0];
`ifdef RESTADOR_SAT_EN
    if (bb) dd = '0;
`endif
    return {bb, dd};
  endfunction
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi, input string tag);
    logic [W:0] e;
    e = model(a, b, bi);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.bi = bi;
    tick();
    bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    bus.bi = $urandom;
    for (int i = 0; i < W; i++) begin
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      chk({tag, "_nodone"}, 32'(bus.done), 32'd0);
      tick();
    end
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_busy_off"}, 32'(bus.busy), 32'd0);
    chk({tag, "_d"}, 32'(bus.d), 32'(e[W-1:0]));
    chk({tag, "_bo"}, 32'(bus.bo), 32'(e[W]));
  endtask
  initial begin
    logic [W:0] e;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.bi = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_d", 32'(bus.d), 32'd0);
    chk("rst_bo", 32'(bus.bo), 32'd0);
    reset_L = 1'b1;
    tick();
    op(8'h5A, 8'h3C, 1'b0, "op5a3c");
    tick();
    chk("done_pulse_1cyc", 32'(bus.done), 32'd0);
    chk("d_held", 32'(bus.d), 32'h1E);
    op(8'h10, 8'h20, 1'b0, "op1020");
    tick();
    op(8'h00, 8'h00, 1'b1, "op0000b");
    tick();
    op(8'hFF, 8'hFF, 1'b0, "opffff");
    tick();
    base = done_cnt;
    e = model(8'h05, 8'h03, 1'b0);
    bus.start = 1'b1;
    bus.a = 8'h05;
    bus.b = 8'h03;
    bus.bi = 1'b0;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    bus.start = 1'b1;
    bus.a = 8'h77;
    bus.b = 8'h11;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < W - 4; i++) tick();
    chk("ign_done", 32'(bus.done), 32'd1);
    chk("ign_d", 32'(bus.d), 32'(e[W-1:0]));
    for (int i = 0; i < W + 2; i++) tick();
    chk("ign_one_done", 32'(done_cnt - base), 32'd1);
    chk("ign_idle", 32'(bus.busy), 32'd0);
    base = done_cnt;
    op(8'h33, 8'h44, 1'b1, "b2b_first");
    op(8'h80, 8'h01, 1'b0, "b2b_second");
    tick();
    tick();
    chk("b2b_two_done", 32'(done_cnt - base), 32'd2);
    for (int k = 0; k < 20; k++) begin
      op(W'($urandom), W'($urandom), 1'($urandom), "rnd");
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();
    base = done_cnt;
    bus.start = 1'b1;
    bus.a = 8'hC3;
    bus.b = 8'h0F;
    bus.bi = 1'b0;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    reset_L = 1'b0;
    tick();
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_d", 32'(bus.d), 32'd0);
    chk("mid_rst_bo", 32'(bus.bo), 32'd0);
    reset_L = 1'b1;
    for (int i = 0; i < 2 * W; i++) tick();
    chk("mid_rst_no_done", 32'(done_cnt - base), 32'd0);
    chk("mid_rst_d_stays", 32'(bus.d), 32'd0);
    op(8'h20, 8'h07, 1'b1, "after_rst");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
